// File: rtl/qam_mapper_param.sv
// qam_mapper_param: serialises WORD_W-bit payload words into 1/2/4/6-bit symbols
// (BPSK/QPSK/16QAM/64QAM), Gray-maps them to signed I/Q amplitudes and streams
// them out over a valid/ready interface with backpressure.
//
// Optional feature: define QAM_SCRAMBLE_EN to XOR every consumed payload bit with
// an additive x^7+x^4+1 LFSR (seed 7'h7F, persists across words).
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   s_data/s_valid    input payload word and its valid
//   s_ready           word accepted this cycle (combinational, zero-bubble)
//   mode              0=BPSK 1=QPSK 2=16QAM 3=64QAM, 4-7 illegal; sampled on accept
//   m_i/m_q           signed I/Q sample
//   m_valid/m_ready   output stream handshake
//   m_last            final symbol of the current word
//   error             sticky illegal-mode flag
module qam_mapper_param #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned IQ_W   = 16,
  parameter int          SCALE  = 2048
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [2:0]             mode,
  output logic signed [IQ_W-1:0] m_i,
  output logic signed [IQ_W-1:0] m_q,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   error
);

  localparam int unsigned CNT_W   = $clog2(WORD_W + 1);
  localparam int unsigned N_BPSK  = WORD_W;
  localparam int unsigned N_QPSK  = WORD_W / 2;
  localparam int unsigned N_16QAM = WORD_W / 4;
  localparam int unsigned N_64QAM = WORD_W / 6;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_d;
  logic [WORD_W-1:0]        shreg, shreg_d;
  logic [2:0]               bps, bps_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic                     mv_d, ml_d, err_d;
  logic signed [IQ_W-1:0]   mi_d, mq_d;

  logic                     hs, last_hs, accept, mode_ok;
  logic [2:0]               mode_bps, src_bps;
  logic [WORD_W-1:0]        src_word;
  logic [5:0]               sym_bits;
  logic [CNT_W-1:0]         src_last;
  logic signed [IQ_W-1:0]   sym_i, sym_q;

`ifdef QAM_SCRAMBLE_EN
  logic [6:0]               lfsr, lfsr_d, lfsr_adv, lfsr_tmp;
  logic                     lfsr_fb;
`endif

  // Gray-coded axis field (zero-extended to 3 bits) -> signed amplitude
  function automatic logic signed [IQ_W-1:0] amp(input logic [2:0] g, input int k);
    logic [2:0] idx;
    int         lvl;
    idx = g ^ (g >> 1) ^ (g >> 2);
    lvl = 2 * int'(idx) - ((1 << k) - 1);
    return IQ_W'(lvl * SCALE);
  endfunction

  assign hs      = m_valid & m_ready;
  assign last_hs = hs & m_last;
  // Open for a new word when idle, or on the final handshake for zero-bubble streaming
  assign s_ready = rst & ((state == IDLE) | last_hs);
  assign accept  = s_ready & s_valid;
  assign mode_ok = ~mode[2];

  // Bits per symbol for the requested mode
  always_comb begin
    mode_bps = 3'd0;
    case (mode)
      3'd0:    mode_bps = 3'd1;
      3'd1:    mode_bps = 3'd2;
      3'd2:    mode_bps = 3'd4;
      3'd3:    mode_bps = 3'd6;
      default: mode_bps = 3'd0;
    endcase
  end

  // Next symbol source: fresh word on accept, otherwise the shifted residue
  always_comb begin
    src_word = accept ? s_data : shreg;
    src_bps  = accept ? mode_bps : bps;
    src_last = '0;
    case (src_bps)
      3'd1:    src_last = CNT_W'(N_BPSK - 1);
      3'd2:    src_last = CNT_W'(N_QPSK - 1);
      3'd4:    src_last = CNT_W'(N_16QAM - 1);
      3'd6:    src_last = CNT_W'(N_64QAM - 1);
      default: src_last = '0;
    endcase
  end

`ifdef QAM_SCRAMBLE_EN
  // Additive scrambler: advance once per consumed bit of the current symbol
  always_comb begin
    lfsr_tmp = lfsr;
    lfsr_fb  = 1'b0;
    sym_bits = src_word[5:0];
    for (int i = 0; i < 6; i++) begin
      if (3'(i) < src_bps) begin
        lfsr_fb     = lfsr_tmp[6] ^ lfsr_tmp[3];
        sym_bits[i] = src_word[i] ^ lfsr_fb;
        lfsr_tmp    = {lfsr_tmp[5:0], lfsr_fb};
      end
    end
    lfsr_adv = lfsr_tmp;
  end
`else
  assign sym_bits = src_word[5:0];
`endif

  // Constellation mapping: I from the low half of the symbol, Q from the high half
  always_comb begin
    sym_i = '0;
    sym_q = '0;
    case (src_bps)
      3'd1: begin
        sym_i = amp({2'b00, sym_bits[0]}, 1);
      end
      3'd2: begin
        sym_i = amp({2'b00, sym_bits[0]}, 1);
        sym_q = amp({2'b00, sym_bits[1]}, 1);
      end
      3'd4: begin
        sym_i = amp({1'b0, sym_bits[1:0]}, 2);
        sym_q = amp({1'b0, sym_bits[3:2]}, 2);
      end
      3'd6: begin
        sym_i = amp(sym_bits[2:0], 3);
        sym_q = amp(sym_bits[5:3], 3);
      end
      default: begin
        sym_i = '0;
        sym_q = '0;
      end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    bps_d   = bps;
    cnt_d   = cnt;
    mv_d    = m_valid;
    ml_d    = m_last;
    mi_d    = m_i;
    mq_d    = m_q;
    err_d   = error;
`ifdef QAM_SCRAMBLE_EN
    lfsr_d  = lfsr;
`endif
    if (accept) begin
      if (mode_ok) begin
        state_d = SEND;
        mv_d    = 1'b1;
        cnt_d   = '0;
        ml_d    = (src_last == '0);
        shreg_d = src_word >> src_bps;
        bps_d   = mode_bps;
        mi_d    = sym_i;
        mq_d    = sym_q;
`ifdef QAM_SCRAMBLE_EN
        lfsr_d  = lfsr_adv;
`endif
      end else begin
        // Illegal mode: word is swallowed, nothing emitted
        err_d   = 1'b1;
        state_d = IDLE;
        mv_d    = 1'b0;
        ml_d    = 1'b0;
      end
    end else if (last_hs) begin
      state_d = IDLE;
      mv_d    = 1'b0;
      ml_d    = 1'b0;
    end else if (hs) begin
      cnt_d   = cnt + CNT_W'(1);
      ml_d    = ((cnt + CNT_W'(1)) == src_last);
      shreg_d = src_word >> src_bps;
      mi_d    = sym_i;
      mq_d    = sym_q;
`ifdef QAM_SCRAMBLE_EN
      lfsr_d  = lfsr_adv;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bps     <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_i     <= '0;
      m_q     <= '0;
      error   <= 1'b0;
`ifdef QAM_SCRAMBLE_EN
      lfsr    <= 7'h7F;
`endif
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bps     <= bps_d;
      cnt     <= cnt_d;
      m_valid <= mv_d;
      m_last  <= ml_d;
      m_i     <= mi_d;
      m_q     <= mq_d;
      error   <= err_d;
`ifdef QAM_SCRAMBLE_EN
      lfsr    <= lfsr_d;
`endif
    end
  end

endmodule
